dw_mac_pe: RTL and testbench

- Depthwise-convolution processing element that sits directly downstream of weight_buffer.
- Accepts the KSIZE*KSIZE kernel weights streamed out of weight_buffer (dw_out / dw_ready) and holds them in a local register file.
- Performs a serial signed multiply-accumulate of one KSIZE*KSIZE pixel window against the held kernel and emits one accumulated result per window.
- Kernel is retained across windows until a reload is requested.

---
 rtl/dw_mac_pe.sv | 239 +++++++++++++++++++++++
 tb/tb_dw_mac_pe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dw_mac_pe.sv
// dw_mac_pe: depthwise-conv PE; holds a KSIZE*KSIZE kernel and MACs one pixel window per result.
// Latency: out_valid rises the cycle after the edge accepting the last pixel of a window.
// Backpressure: w/px valid-ready stall the counters; out_data/out_valid hold until out_ready.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   w_valid/w_data/w_ready          kernel weight stream (weight_buffer dw_out/dw_ready)
//   kernel_reload/kernel_loaded     reload request pulse / complete kernel held flag
//   px_valid/px_data/px_ready       pixel stream, raster order 0..K2-1 per window
//   out_valid/out_data/out_ready    signed window sum of w[i]*px[i]
//
// Optional build macro: DW_MAC_PE_RELU6_EN clamps the registered result to
// [0, 6<<(DW/2)] (MobileNet ReLU6 on a DW/2-fractional-bit fixed-point sum).
module dw_mac_pe #(
    parameter int DW    = 32,
    parameter int KSIZE = 3,
    parameter int ACCW  = 2*DW + $clog2(KSIZE*KSIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_valid,
    input  logic [DW-1:0]   w_data,
    output logic            w_ready,
    input  logic            kernel_reload,
    output logic            kernel_loaded,
    input  logic            px_valid,
    input  logic [DW-1:0]   px_data,
    output logic            px_ready,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    input  logic            out_ready
);

    localparam int K2 = KSIZE*KSIZE;
    localparam int IW = (K2 > 1) ? $clog2(K2) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K2-1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0]          widx_q, widx_d;
    logic [IW-1:0]          pidx_q, pidx_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] out_q, out_d;
    logic                   reload_pend_q, reload_pend_d;
    logic                   loaded_q, loaded_d;

    // Kernel storage: intentionally not reset, a reload always rewrites every entry.
    logic [DW-1:0]          wreg_q [K2];

    logic                   w_fire;
    logic                   px_fire;
    logic                   out_fire;
    logic                   reload_req;
    logic                   reload_now;
    logic                   w_last;
    logic                   px_last;

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_base;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] result;

    // A reload is wanted if one is already pending or is being pulsed right now.
    assign reload_req = reload_pend_q | kernel_reload;

    // Reload is only allowed to take effect on a window boundary in RUN; it
    // preempts the first pixel of the next window.
    assign reload_now = (state_q == S_RUN) && (pidx_q == '0) && reload_req;

    assign w_fire   = w_valid  & w_ready;
    assign px_fire  = px_valid & px_ready;
    assign out_fire = out_valid & out_ready;

    assign w_last  = (widx_q == LAST_IDX);
    assign px_last = (pidx_q == LAST_IDX);

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (w_fire && w_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (reload_now) begin
                    state_d = S_LOAD;
                end else if (px_fire && px_last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    state_d = reload_req ? S_LOAD : S_RUN;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs
    //------------------------------------------------------------------
    always_comb begin
        w_ready   = (state_q == S_LOAD);
        // px_ready drops in the reload cycle so no pixel is consumed by the
        // old kernel once the switch to LOAD has been decided.
        px_ready  = (state_q == S_RUN) && !reload_now;
        out_valid = (state_q == S_OUT);
    end

    assign kernel_loaded = loaded_q;
    assign out_data      = out_q;

    //------------------------------------------------------------------
    // Datapath: full-precision signed product, sign-extended into ACCW
    //------------------------------------------------------------------
    always_comb begin
        prod     = $signed(wreg_q[pidx_q]) * $signed(px_data);
        // The first pixel of a window restarts the sum instead of adding to
        // whatever the previous window left behind.
        acc_base = (pidx_q == '0) ? ACCW'(0) : acc_q;
        sum      = acc_base + ACCW'(prod);
    end

`ifdef DW_MAC_PE_RELU6_EN
    localparam logic signed [ACCW-1:0] RELU6_MAX = ACCW'(6) << (DW/2);

    always_comb begin
        if (sum < 0) begin
            result = '0;
        end else if (sum > RELU6_MAX) begin
            result = RELU6_MAX;
        end else begin
            result = sum;
        end
    end
`else
    always_comb begin
        result = sum;
    end
`endif

    //------------------------------------------------------------------
    // Counter / accumulator / flag next-state
    //------------------------------------------------------------------
    always_comb begin
        widx_d        = widx_q;
        pidx_d        = pidx_q;
        acc_d         = acc_q;
        out_d         = out_q;
        reload_pend_d = reload_pend_q | kernel_reload;
        loaded_d      = loaded_q;

        case (state_q)
            S_LOAD: begin
                if (w_fire) begin
                    if (w_last) begin
                        widx_d        = '0;
                        loaded_d      = 1'b1;
                        // The kernel just loaded satisfies any request seen during LOAD.
                        reload_pend_d = 1'b0;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (reload_now) begin
                    loaded_d      = 1'b0;
                    reload_pend_d = 1'b0;
                end else if (px_fire) begin
                    acc_d = sum;
                    if (px_last) begin
                        pidx_d = '0;
                        out_d  = result;
                    end else begin
                        pidx_d = pidx_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_fire && reload_req) begin
                    loaded_d      = 1'b0;
                    reload_pend_d = 1'b0;
                end
            end
            default: begin
                widx_d = '0;
                pidx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            widx_q        <= '0;
            pidx_q        <= '0;
            acc_q         <= '0;
            out_q         <= '0;
            reload_pend_q <= 1'b0;
            loaded_q      <= 1'b0;
        end else begin
            widx_q        <= widx_d;
            pidx_q        <= pidx_d;
            acc_q         <= acc_d;
            out_q         <= out_d;
            reload_pend_q <= reload_pend_d;
            loaded_q      <= loaded_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            wreg_q[widx_q] <= w_data;
        end
    end

endmodule

// File: tb/tb_dw_mac_pe.sv
`timescale 1ns/1ps
module tb_dw_mac_pe;

    localparam int DW   = 32;
    localparam int K2   = 9;
    localparam int ACCW = 2*DW + $clog2(K2);
    localparam int TMO  = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            w_valid = 1'b0;
    logic [DW-1:0]   w_data = '0;
    logic            w_ready;
    logic            kernel_reload = 1'b0;
    logic            kernel_loaded;
    logic            px_valid = 1'b0;
    logic [DW-1:0]   px_data = '0;
    logic            px_ready;
    logic            out_valid;
    logic [ACCW-1:0] out_data;
    logic            out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int kw [K2];
    int kp [K2];

    always #5 clk = ~clk;

    dw_mac_pe #(.DW(DW), .KSIZE(3), .ACCW(ACCW)) dut (
        .clk           (clk),
        .rst           (rst),
        .w_valid       (w_valid),
        .w_data        (w_data),
        .w_ready       (w_ready),
        .kernel_reload (kernel_reload),
        .kernel_loaded (kernel_loaded),
        .px_valid      (px_valid),
        .px_data       (px_data),
        .px_ready      (px_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready)
    );

    // Expected result as seen on out_data, including the optional ReLU6 clamp.
    function automatic longint exp_out(input longint v);
        longint r;
        r = v;
`ifdef DW_MAC_PE_RELU6_EN
        if (v < 0) r = 0;
        else if (v > (longint'(6) << (DW/2))) r = longint'(6) << (DW/2);
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [127:0] obs,
                       input logic signed [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send_w(input int v, input int gap);
        int n;
        n = 0;
        w_data  = DW'(v);
        w_valid = 1'b1;
        while (!w_ready && n < TMO) begin
            step();
            n++;
        end
        checks++;
        assert (n < TMO) else begin
            errors++;
            $error("FAIL w_timeout observed=%0d expected<%0d", n, TMO);
        end
        step();
        w_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_p(input int v, input int gap);
        int n;
        n = 0;
        px_data  = DW'(v);
        px_valid = 1'b1;
        while (!px_ready && n < TMO) begin
            step();
            n++;
        end
        checks++;
        assert (n < TMO) else begin
            errors++;
            $error("FAIL px_timeout observed=%0d expected<%0d", n, TMO);
        end
        step();
        px_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic load_kernel(input int gap);
        for (int i = 0; i < K2; i++) send_w(kw[i], (i == K2-1) ? 0 : gap);
    endtask

    // Sends kp[lo..hi]; no idle gap after the final pixel so the caller
    // lands in the cycle right after the accepting edge.
    task automatic send_px(input int lo, input int hi, input int gap);
        for (int i = lo; i <= hi; i++) send_p(kp[i], (i == hi) ? 0 : gap);
    endtask

    // Reload on a window boundary: px_ready must drop in the pulse cycle.
    task automatic reload_idle(input string tag);
        kernel_reload = 1'b1;
        #1;
        chk({tag, "_px_ready_blocked"}, px_ready, 0);
        step();
        kernel_reload = 1'b0;
        chk({tag, "_w_ready"}, w_ready, 1);
        chk({tag, "_kernel_loaded"}, kernel_loaded, 0);
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) step();
        rst = 1'b0;
        chk("rst_w_ready", w_ready, 1);
        chk("rst_px_ready", px_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_kernel_loaded", kernel_loaded, 0);
        chk("rst_out_data", $signed(out_data), 0);

        // ---------------- weights 1..9, pixels 2 -> 2*45 = 90 ----------------
        out_ready = 1'b1;
        for (int i = 0; i < K2; i++) kw[i] = i + 1;
        load_kernel(0);
        chk("load_kernel_loaded", kernel_loaded, 1);
        chk("load_w_ready_low", w_ready, 0);
        chk("load_px_ready", px_ready, 1);
        for (int i = 0; i < K2; i++) kp[i] = 2;
        send_px(0, K2-1, 0);
        chk("win1_latency", out_valid, 1);
        chk("win1_sum", $signed(out_data), exp_out(90));
        step();
        chk("win1_valid_one_cycle", out_valid, 0);

        // ---------------- signed: w = -1,+1,...; px = 0..8 ----------------
        // (1+3+5+7) - (0+2+4+6+8) = 16 - 20 = -4
        reload_idle("sgn");
        for (int i = 0; i < K2; i++) kw[i] = (i % 2 == 0) ? -1 : 1;
        load_kernel(0);
        for (int i = 0; i < K2; i++) kp[i] = i;
        send_px(0, K2-1, 0);
        chk("sgn_sum", $signed(out_data), exp_out(-4));
        step();

        // ---------------- backpressure ----------------
        reload_idle("bp");
        for (int i = 0; i < K2; i++) kw[i] = i + 1;
        load_kernel(1);
        chk("bp_kernel_loaded", kernel_loaded, 1);
        out_ready = 1'b0;
        for (int i = 0; i < K2; i++) kp[i] = 2;
        send_px(0, K2-1, 1);
        chk("bp_valid", out_valid, 1);
        chk("bp_sum", $signed(out_data), exp_out(90));
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", $signed(out_data), exp_out(90));
            chk("bp_hold_px_ready", px_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_px_ready", px_ready, 1);

        // ---------------- retention: two windows, same kernel ----------------
        for (int i = 0; i < K2; i++) kp[i] = 1;
        send_px(0, K2-1, 0);
        chk("ret_win_a", $signed(out_data), exp_out(45));
        // sum i*(i+1), i=0..8 = 204 + 36 = 240
        for (int i = 0; i < K2; i++) kp[i] = i;
        send_px(0, K2-1, 0);
        chk("ret_win_b", $signed(out_data), exp_out(240));

        // ---------------- reload mid-window (pidx=4) ----------------
        for (int i = 0; i < K2; i++) kp[i] = 1;
        send_px(0, 3, 0);
        kernel_reload = 1'b1;
        #1;
        chk("mid_px_ready_kept", px_ready, 1);
        step();
        kernel_reload = 1'b0;
        out_ready = 1'b0;
        send_px(4, K2-1, 0);
        chk("mid_old_kernel_sum", $signed(out_data), exp_out(45));
        chk("mid_kernel_loaded_held", kernel_loaded, 1);
        out_ready = 1'b1;
        step();
        chk("mid_after_hs_w_ready", w_ready, 1);
        chk("mid_after_hs_kernel_loaded", kernel_loaded, 0);
        chk("mid_after_hs_out_valid", out_valid, 0);
        for (int i = 0; i < K2; i++) kw[i] = 2;
        load_kernel(0);
        for (int i = 0; i < K2; i++) kp[i] = i;
        out_ready = 1'b0;
        send_px(0, K2-1, 0);
        chk("mid_new_kernel_sum", $signed(out_data), exp_out(72));

        // ---------------- reload on the same edge as OUT handshake ----------------
        out_ready     = 1'b1;
        kernel_reload = 1'b1;
        step();
        kernel_reload = 1'b0;
        chk("sim_w_ready", w_ready, 1);
        chk("sim_kernel_loaded", kernel_loaded, 0);

        // ---------------- reset mid-window ----------------
        for (int i = 0; i < K2; i++) kw[i] = i + 1;
        load_kernel(0);
        for (int i = 0; i < K2; i++) kp[i] = 2;
        send_px(0, 4, 0);
        rst = 1'b1;
        step();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_w_ready", w_ready, 1);
        chk("mrst_kernel_loaded", kernel_loaded, 0);
        chk("mrst_px_ready", px_ready, 0);
        rst = 1'b0;
        // weights 9..1, pixels 0..8: 9*36 - 204 = 120
        for (int i = 0; i < K2; i++) kw[i] = 9 - i;
        load_kernel(0);
        for (int i = 0; i < K2; i++) kp[i] = i;
        send_px(0, K2-1, 0);
        chk("mrst_sum", $signed(out_data), exp_out(120));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
